// File: rtl/async_fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// State encoding is fixed: IDLE=0, BUSY=1.
package async_fifo_wr_arbiter_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

    localparam int unsigned DefDataWidth = 4;

    // clog2 that never returns 0, so single-value ranges still get a 1-bit signal
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/async_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after rr_ptr_i, wrapping.
module async_fifo_wr_arbiter_rr_pick
    import async_fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NumReq = 4,
    localparam int unsigned IdxW = clog2_min1(NumReq)
) (
    input  logic [NumReq-1:0] req_valid_i,
    input  logic [IdxW-1:0]   rr_ptr_i,
    output logic [NumReq-1:0] pick_onehot_o,
    output logic [IdxW-1:0]   pick_idx_o,
    output logic              any_o
);

    int unsigned idx;

    always_comb begin
        pick_onehot_o = '0;
        pick_idx_o    = '0;
        idx           = 0;
        // Walk from farthest to nearest so the nearest valid index wins
        for (int k = NumReq - 1; k >= 0; k--) begin
            idx = 32'(rr_ptr_i) + 32'(k);
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (req_valid_i[idx]) begin
                pick_onehot_o      = '0;
                pick_onehot_o[idx] = 1'b1;
                pick_idx_o         = IdxW'(idx);
            end
        end
    end

    assign any_o = |req_valid_i;

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing the FIFO write port among NUM_REQ producers.
// A grant is held until req_last or MAX_BURST beats, whichever comes first.
module async_fifo_wr_arbiter
    import async_fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                          wr_clk,
    input  logic                          wr_rstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          burst_trunc
);

    localparam int unsigned IdxW = clog2_min1(NUM_REQ);
    localparam int unsigned CntW = clog2_min1(MAX_BURST + 1);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IdxW-1:0]     gidx_q, gidx_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]     beat_cnt_q, beat_cnt_d;
    logic                trunc_q, trunc_d;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IdxW-1:0]     pick_idx;
    logic                pick_any;
    logic                xfer;
    logic                pkt_end;

    async_fifo_wr_arbiter_rr_pick #(
        .NumReq (NUM_REQ)
    ) u_rr_pick (
        .req_valid_i   (req_valid),
        .rr_ptr_i      (rr_ptr_q),
        .pick_onehot_o (pick_onehot),
        .pick_idx_o    (pick_idx),
        .any_o         (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        trunc_d      = 1'b0;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        xfer         = 1'b0;
        pkt_end      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_d    = pick_onehot;
                    gidx_d     = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                req_ready = grant_q & {NUM_REQ{~fifo_full}};
                xfer      = req_valid[gidx_q] & ~fifo_full;
                if (xfer) begin
                    fifo_wr_en   = 1'b1;
                    fifo_wr_data = req_data[gidx_q*DATA_WIDTH +: DATA_WIDTH];
                    beat_cnt_d   = beat_cnt_q + CntW'(1);
                    pkt_end      = req_last[gidx_q] || (beat_cnt_q == CntW'(MAX_BURST - 1));
                    if (pkt_end) begin
                        state_d  = StIdle;
                        grant_d  = '0;
                        rr_ptr_d = (gidx_q == IdxW'(NUM_REQ - 1)) ? '0 : gidx_q + IdxW'(1);
                        trunc_d  = ~req_last[gidx_q];
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Write side stays quiet for the whole time reset is held
        if (!wr_rstn) begin
            req_ready    = '0;
            fifo_wr_en   = 1'b0;
            fifo_wr_data = '0;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            trunc_q    <= trunc_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q == StBusy);
    assign burst_trunc = trunc_q;

endmodule
